ret_stack: RTL and testbench
============================

RET_STACK -- requirements
Module: ret_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the return-address (PC) width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of entries (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port push, input, 1 bit: the write request from the control unit.
REQ-006 The block SHALL have port pop, input, 1 bit: the read/remove request from the control unit.
REQ-007 The block SHALL have port data_in, input, WIDTH bits: the return address to store (PC+1).
REQ-008 The block SHALL have port data_out, output, WIDTH bits: the top-of-stack value, combinational.
REQ-009 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-010 The block SHALL have ports empty and full, outputs, 1 bit each: occupancy flags.
REQ-011 The block SHALL have ports err_ovf and err_unf, outputs, 1 bit each: sticky overflow and underflow flags.

Function
REQ-012 Storage SHALL be a LIFO with stack pointer sp equal to count; the next push goes to mem[sp] and the top is mem[sp-1].
REQ-013 data_out SHALL equal mem[sp-1] combinationally when count>0 and all-zeros when empty, so a pop in a single-cycle CPU reads the return address in the same cycle.
REQ-014 Push only, not full: mem[sp] SHALL take data_in and count SHALL increment at the clock edge; latency to data_out is 1 cycle.
REQ-015 Pop only, not empty: count SHALL decrement at the clock edge and memory contents SHALL be unchanged.
REQ-016 Push and pop together, not empty: mem[sp-1] SHALL take data_in and count SHALL be unchanged (top replaced).
REQ-017 Push and pop together, empty: the operation SHALL behave as push only, and err_unf SHALL be set.
REQ-018 Push while full (without pop): the write SHALL be dropped, count SHALL stay DEPTH, and err_ovf SHALL be set.
REQ-019 Pop while empty (without push): count SHALL stay 0 and err_unf SHALL be set.
REQ-020 empty SHALL be (count==0) and full SHALL be (count==DEPTH), both combinational from count.
REQ-021 count SHALL never wrap; its range is 0..DEPTH inclusive.
REQ-022 err_ovf and err_unf SHALL stay set until reset.

Reset
REQ-023 While reset is low, count SHALL be 0, empty SHALL be 1, full SHALL be 0, err_ovf and err_unf SHALL be 0, and data_out SHALL be 0, asynchronously.
REQ-024 Memory contents need not be cleared; they SHALL be unobservable while empty.
REQ-025 Reset asserted during push or pop SHALL win; the first edge after reset release SHALL be processed normally.

Configuration
REQ-026 When RET_STACK_ERR_EN is defined, err_ovf and err_unf SHALL behave per REQ-017 to REQ-019 and REQ-022.
REQ-027 When RET_STACK_ERR_EN is undefined, err_ovf and err_unf SHALL be tied 0, no flag registers SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Package ret_stack_pkg SHALL hold the default WIDTH, the default DEPTH, and a pointer-width localparam helper.
REQ-029 Sub-module ret_stack_mem SHALL hold the register array: one write port (addr, data, we), one asynchronous read port, and no reset.
REQ-030 Pointer and flag logic SHALL reside in ret_stack.

Verification
REQ-031 Reset low, then push 0x005, 0x0A3, 0x1FF -> count=3 and data_out=0x1FF; then pop three times -> data_out 0x0A3, then 0x005, then 0, with empty=1.
REQ-032 Push DEPTH=8 values 1..8, then push 9 -> count=8, full=1, data_out=8, and err_ovf=1 (0 without RET_STACK_ERR_EN).
REQ-033 Empty stack, pop -> count=0, data_out=0, err_unf=1; then push 0x010 -> count=1 and err_unf stays 1.
REQ-034 Stack holding 0x020, push and pop together with data_in=0x030 -> count=1 and data_out=0x030; same stimulus on an empty stack -> count=1, data_out=0x030, err_unf=1.
REQ-035 Assert reset asynchronously mid-cycle with count=5 -> count=0, empty=1, and flags cleared immediately without waiting for clk.

Source files
------------

// File: rtl/ret_stack_pkg.sv
// ret_stack_pkg: shared defaults and pointer-width helper for the return-address stack.
`default_nettype none

package ret_stack_pkg;

   localparam int DEF_WIDTH = 10;
   localparam int DEF_DEPTH = 8;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack_if.sv
// ret_stack_if: control-unit <-> return-stack bus; master drives requests, slave reports state.
`default_nettype none

interface ret_stack_if
   import ret_stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = ptr_w(DEPTH) + 1;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err_ovf;
   logic             err_unf;

   modport master (
      output push, pop, data_in,
      input  data_out, count, empty, full, err_ovf, err_unf
   );

   modport slave (
      input  push, pop, data_in,
      output data_out, count, empty, full, err_ovf, err_unf
   );

endinterface

`default_nettype wire

// File: rtl/ret_stack_mem.sv
// ret_stack_mem: unreset register array, one synchronous write port and one asynchronous read port.
`default_nettype none

module ret_stack_mem
   import ret_stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ret_stack.sv
// ret_stack: LIFO return-address stack with stack pointer == count and combinational top-of-stack.
// Sticky overflow/underflow flags exist only when RET_STACK_ERR_EN is defined.
`default_nettype none

module ret_stack
   import ret_stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   ret_stack_if.slave    bus
);

   localparam int             AW     = ptr_w(DEPTH);
   localparam int             CW     = AW + 1;
   localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

   logic [CW-1:0]    count_q, count_d;
   logic             empty, full, we;
   logic [AW-1:0]    waddr, top_addr;
   logic [WIDTH-1:0] rdata;

   assign empty    = (count_q == '0);
   assign full     = (count_q == C_FULL);
   // Wraps to DEPTH-1 when full, which is exactly the top slot.
   assign top_addr = count_q[AW-1:0] - AW'(1);

   always_comb begin
      we      = 1'b0;
      waddr   = count_q[AW-1:0];
      count_d = count_q;
      unique case ({bus.push, bus.pop})
         2'b10: begin
            if (!full) begin
               we      = 1'b1;
               count_d = count_q + CW'(1);
            end
         end
         2'b01: begin
            if (!empty) begin
               count_d = count_q - CW'(1);
            end
         end
         2'b11: begin
            we = 1'b1;
            if (empty) begin
               count_d = count_q + CW'(1);
            end else begin
               waddr = top_addr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   ret_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (bus.data_in),
      .raddr_i (top_addr),
      .rdata_o (rdata)
   );

   assign bus.data_out = empty ? '0 : rdata;
   assign bus.count    = count_q;
   assign bus.empty    = empty;
   assign bus.full     = full;

`ifdef RET_STACK_ERR_EN
   logic err_ovf_q, err_unf_q;

   // Any pop against an empty stack is an underflow, with or without a push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         if (bus.push && !bus.pop && full) err_ovf_q <= 1'b1;
         if (bus.pop && empty)             err_unf_q <= 1'b1;
      end
   end

   assign bus.err_ovf = err_ovf_q;
   assign bus.err_unf = err_unf_q;
`else
   assign bus.err_ovf = 1'b0;
   assign bus.err_unf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ret_stack.sv
// tb_ret_stack: table-driven vectors plus hand sequences, checked through an expected-value queue.
`default_nettype none

module tb_ret_stack;

   localparam int WIDTH = 10;
   localparam int DEPTH = 8;
   localparam int CW    = 4;
`ifdef RET_STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   ret_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0]    cnt;
      logic [WIDTH-1:0] dout;
      logic             ovf;
      logic             unf;
   } exp_t;

   typedef struct {
      logic             p;
      logic             po;
      logic [WIDTH-1:0] d;
      logic [CW-1:0]    c;
      logic [WIDTH-1:0] q;
      logic             o;
      logic             u;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic check_state(input string tag, input exp_t e);
      chk({tag, ".count"},   32'(bus.count),    32'(e.cnt));
      chk({tag, ".dout"},    32'(bus.data_out), 32'(e.dout));
      chk({tag, ".empty"},   32'(bus.empty),    32'(e.cnt == 0));
      chk({tag, ".full"},    32'(bus.full),     32'(e.cnt == CW'(DEPTH)));
      chk({tag, ".err_ovf"}, 32'(bus.err_ovf),  32'(e.ovf & ERR_EN));
      chk({tag, ".err_unf"}, 32'(bus.err_unf),  32'(e.unf & ERR_EN));
   endtask

   task automatic step(input string tag, input logic p, input logic po,
                       input logic [WIDTH-1:0] d, input logic [CW-1:0] ec,
                       input logic [WIDTH-1:0] ed, input logic eo, input logic eu);
      exp_t e;
      @(negedge clk);
      bus.push    = p;
      bus.pop     = po;
      bus.data_in = d;
      e.cnt = ec; e.dout = ed; e.ovf = eo; e.unf = eu;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_state(tag, e);
      end
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      tbl[0] = '{1'b1, 1'b0, 10'h005, 4'd1, 10'h005, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 10'h0A3, 4'd2, 10'h0A3, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 10'h1FF, 4'd3, 10'h1FF, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 10'h000, 4'd2, 10'h0A3, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 10'h000, 4'd1, 10'h005, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 10'h010, 4'd1, 10'h010, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 1'b1, 10'h030, 4'd1, 10'h030, 1'b0, 1'b1};
      tbl[9] = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 1'b0, 1'b1};

      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = '0;
      reset       = 1'b1;
      #1 reset = 1'b0;
      #1;
      e = '{4'd0, 10'h000, 1'b0, 1'b0};
      check_state("reset", e);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step($sformatf("tbl%0d", i), tbl[i].p, tbl[i].po, tbl[i].d,
              tbl[i].c, tbl[i].q, tbl[i].o, tbl[i].u);
      end

      // push+pop on an empty stack acts as push and flags underflow
      do_reset();
      step("pp_empty", 1'b1, 1'b1, 10'h030, 4'd1, 10'h030, 1'b0, 1'b1);
      step("pp_pop",   1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 1'b0, 1'b1);

      // fill, overflow, replace top while full, drain
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         step($sformatf("fill%0d", i), 1'b1, 1'b0, WIDTH'(i), CW'(i), WIDTH'(i), 1'b0, 1'b0);
      end
      step("ovf_push", 1'b1, 1'b0, 10'h009, 4'd8, 10'h008, 1'b1, 1'b0);
      step("pp_full",  1'b1, 1'b1, 10'h3AA, 4'd8, 10'h3AA, 1'b1, 1'b0);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         step($sformatf("drain%0d", i), 1'b0, 1'b1, '0, CW'(i), WIDTH'(i), 1'b1, 1'b0);
      end
      for (int k = 1; k <= 5; k++) begin
         step($sformatf("refill%0d", k), 1'b1, 1'b0, WIDTH'(10'h100 + k),
              CW'(k), WIDTH'(10'h100 + k), 1'b1, 1'b0);
      end

      // asynchronous reset mid-cycle, observed before the next clock edge
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      e = '{4'd0, 10'h000, 1'b0, 1'b0};
      check_state("async_rst", e);

      // push held through reset is ignored; first edge after release is processed
      bus.push    = 1'b1;
      bus.data_in = 10'h155;
      @(posedge clk);
      #1;
      check_state("rst_push", e);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      e = '{4'd1, 10'h155, 1'b0, 1'b0};
      check_state("post_rst", e);
      bus.push = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
